// File: rtl/ip_codma_crc32.sv
// CRC stage of the codma datapath.
// Folds the bytes of each accepted 32-bit word into a reflected CRC-32 register
// (byte lane 0 first, LSB first) and presents the finished, XOR-ed result
// until the DMA controller acknowledges it.
module ip_codma_crc32 #(
  parameter logic [31:0] POLY_REFL  = 32'hEDB88320,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  bytes_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic [31:0] crc_o,
  output logic        crc_valid_o,
  input  logic        ack_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    CRC_IDLE = 2'd0,
    CRC_RUN  = 2'd1,
    CRC_DONE = 2'd2
  } crc_state_t;

  crc_state_t  r_state;
  crc_state_t  w_state_cur;
  crc_state_t  w_state_next;
  logic [31:0] r_crc;
  logic [31:0] r_crc_out;
  logic [31:0] w_crc_next;
  logic [31:0] w_crc_out_next;
  logic [31:0] w_crc_upd;
  logic [2:0]  w_nbytes;
  logic        w_ready;
  logic        w_accept;

  // One byte of the reflected CRC: xor the byte in, then shift out eight bits.
  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h000000, data};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  // A byte count of zero encodes a full word.
  assign w_nbytes = (bytes_i == 2'd0) ? 3'd4 : {1'b0, bytes_i};

  // Four chained byte stages; lanes beyond the valid count pass the value through.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [31:0] w_in;
    logic [31:0] w_out;
    if (gi == 0) begin : g_first
      assign w_in = r_crc;
    end else begin : g_chain
      assign w_in = g_byte[gi-1].w_out;
    end
    assign w_out = (3'(gi) < w_nbytes) ? f_crc_byte(w_in, data_i[8*gi +: 8]) : w_in;
  end

  assign w_crc_upd = g_byte[3].w_out;

  // The unused encoding 3 behaves exactly like idle.
  always_comb begin
    case (r_state)
      CRC_RUN:  w_state_cur = CRC_RUN;
      CRC_DONE: w_state_cur = CRC_DONE;
      default:  w_state_cur = CRC_IDLE;
    endcase
  end

  // A restart or abort cycle never consumes a beat, so ready drops for it.
  assign w_ready  = (w_state_cur == CRC_RUN) && !start_i && !abort_i;
  assign w_accept = valid_i && w_ready;

  // Next-state and datapath selection; abort overrides every other request.
  always_comb begin
    w_state_next   = w_state_cur;
    w_crc_next     = r_crc;
    w_crc_out_next = r_crc_out;
    if (abort_i) begin
      w_state_next = CRC_IDLE;
    end else begin
      case (w_state_cur)
        CRC_IDLE: begin
          if (start_i) begin
            w_crc_next   = CRC_INIT;
            w_state_next = CRC_RUN;
          end
        end
        CRC_RUN: begin
          if (start_i) begin
            w_crc_next = CRC_INIT;
          end else if (w_accept) begin
            w_crc_next = w_crc_upd;
            if (last_i) begin
              w_crc_out_next = w_crc_upd ^ CRC_XOROUT;
              w_state_next   = CRC_DONE;
            end
          end
        end
        CRC_DONE: begin
          if (start_i) begin
            w_crc_next   = CRC_INIT;
            w_state_next = CRC_RUN;
          end else if (ack_i) begin
            w_state_next = CRC_IDLE;
          end
        end
        default: w_state_next = CRC_IDLE;
      endcase
    end
  end

  // State, running CRC and held result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CRC_IDLE;
      r_crc     <= CRC_INIT;
      r_crc_out <= 32'h00000000;
    end else begin
      r_state   <= w_state_next;
      r_crc     <= w_crc_next;
      r_crc_out <= w_crc_out_next;
    end
  end

  assign ready_o     = w_ready;
  assign crc_o       = r_crc_out;
  assign crc_valid_o = (w_state_cur == CRC_DONE);
  assign busy_o      = (w_state_cur != CRC_IDLE);

endmodule

// File: tb/tb_ip_codma_crc32.sv
// Directed plus randomized bench for the CRC-32 stage; expected CRCs come from a
// byte-queue reference computation of the IEEE 802.3 reflected CRC.
module tb_ip_codma_crc32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        abort_i;
  logic [31:0] data_i;
  logic [1:0]  bytes_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [31:0] crc_o;
  logic        crc_valid_o;
  logic        ack_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ip_codma_crc32 dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .data_i     (data_i),
    .bytes_i    (bytes_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .crc_o      (crc_o),
    .crc_valid_o(crc_valid_o),
    .ack_i      (ack_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Reference: CRC-32/ISO-HDLC over a plain list of message bytes.
  function automatic logic [31:0] ref_crc(input logic [7:0] msg[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (msg[i]) begin
      c = c ^ {24'h0, msg[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Start a message, send its words with random idle gaps, check the 1-cycle result.
  task automatic run_msg(input string tag, input logic [31:0] w[$], input logic [1:0] nb[$],
                         input int maxgap, input logic do_start);
    logic [7:0]  bytes_q[$];
    logic [31:0] exp;
    int          n;
    bytes_q = {};
    foreach (w[i]) begin
      n = (nb[i] == 2'd0) ? 4 : int'(nb[i]);
      for (int j = 0; j < n; j++) bytes_q.push_back(w[i][8*j +: 8]);
    end
    exp = ref_crc(bytes_q);
    if (do_start) pulse_start();
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
    foreach (w[i]) begin
      int gap;
      gap = $urandom_range(maxgap, 0);
      for (int g = 0; g < gap; g++) tick();
      data_i  = w[i];
      bytes_i = nb[i];
      last_i  = (i == w.size() - 1);
      valid_i = 1'b1;
      #1;
      chk({tag, "_ready"}, {31'h0, ready_o}, 32'h1);
      chk({tag, "_novalid_early"}, {31'h0, crc_valid_o}, 32'h0);
      tick();
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
    chk({tag, "_valid"}, {31'h0, crc_valid_o}, 32'h1);
    chk({tag, "_crc"}, crc_o, exp);
    $display("msg %s words=%0d bytes=%0d crc=%h expected=%h", tag, w.size(), bytes_q.size(), crc_o, exp);
  endtask

  task automatic do_ack(input string tag);
    logic [31:0] held;
    held  = crc_o;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk({tag, "_ack_valid"}, {31'h0, crc_valid_o}, 32'h0);
    chk({tag, "_ack_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_ack_keep"}, crc_o, held);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [1:0]  nb[$];
    logic [31:0] held;

    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; data_i = 32'h0;
    bytes_i = 2'd0; valid_i = 1'b0; last_i = 1'b0; ack_i = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_crc", crc_o, 32'h0);
    chk("rst_valid", {31'h0, crc_valid_o}, 32'h0);
    chk("rst_ready", {31'h0, ready_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);

    // Test 1: "123456789"
    w = '{32'h34333231, 32'h38373635, 32'h00000039}; nb = '{2'd0, 2'd0, 2'd1};
    run_msg("t1", w, nb, 0, 1'b1);
    chk("t1_check", crc_o, 32'hCBF43926);
    do_ack("t1");

    // Test 2: four zero bytes, result held while ack is withheld
    w = '{32'h00000000}; nb = '{2'd0};
    run_msg("t2", w, nb, 0, 1'b1);
    chk("t2_check", crc_o, 32'h2144DF1C);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_hold_crc", crc_o, 32'h2144DF1C);
      chk("t2_hold_valid", {31'h0, crc_valid_o}, 32'h1);
      chk("t2_hold_ready", {31'h0, ready_o}, 32'h0);
    end
    do_ack("t2");

    // Test 3: gaps between beats; a word offered in DONE is not taken
    w = '{32'h34333231, 32'h38373635, 32'h00000039}; nb = '{2'd0, 2'd0, 2'd1};
    run_msg("t3", w, nb, 3, 1'b1);
    data_i = 32'hDEADBEEF; bytes_i = 2'd0; last_i = 1'b1; valid_i = 1'b1;
    #1;
    chk("t3_done_ready", {31'h0, ready_o}, 32'h0);
    tick(); tick();
    valid_i = 1'b0; last_i = 1'b0;
    chk("t3_done_crc", crc_o, 32'hCBF43926);
    chk("t3_done_valid", {31'h0, crc_valid_o}, 32'h1);
    do_ack("t3");

    // Test 4: abort after the first word
    pulse_start();
    data_i = 32'h34333231; bytes_i = 2'd0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t4_abort_busy", {31'h0, busy_o}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk("t4_abort_novalid", {31'h0, crc_valid_o}, 32'h0);
      tick();
    end
    w = '{32'h34333231, 32'h38373635, 32'h00000039}; nb = '{2'd0, 2'd0, 2'd1};
    run_msg("t4", w, nb, 1, 1'b1);
    chk("t4_check", crc_o, 32'hCBF43926);
    do_ack("t4");

    // Test 5: restart in RUN, the same-cycle word must be dropped
    pulse_start();
    data_i = 32'h34333231; bytes_i = 2'd0; valid_i = 1'b1;
    tick();
    data_i = 32'h38373635; start_i = 1'b1;
    #1;
    chk("t5_restart_ready", {31'h0, ready_o}, 32'h0);
    tick();
    start_i = 1'b0; valid_i = 1'b0;
    w = '{32'h34333231, 32'h38373635, 32'h00000039}; nb = '{2'd0, 2'd0, 2'd1};
    run_msg("t5", w, nb, 0, 1'b0);
    chk("t5_check", crc_o, 32'hCBF43926);

    // start in DONE acts as ack plus start
    pulse_start();
    chk("t5_done_start_valid", {31'h0, crc_valid_o}, 32'h0);
    w = '{32'h00000000}; nb = '{2'd0};
    run_msg("t5b", w, nb, 0, 1'b0);
    do_ack("t5b");

    // Test 6: reset in RUN and in DONE
    pulse_start();
    data_i = 32'h12345678; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_run_busy", {31'h0, busy_o}, 32'h0);
    chk("t6_run_ready", {31'h0, ready_o}, 32'h0);
    chk("t6_run_valid", {31'h0, crc_valid_o}, 32'h0);
    w = '{32'h00000000}; nb = '{2'd0};
    run_msg("t6", w, nb, 0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_done_crc", crc_o, 32'h0);
    chk("t6_done_valid", {31'h0, crc_valid_o}, 32'h0);
    chk("t6_done_busy", {31'h0, busy_o}, 32'h0);

    // Randomized messages with random lengths, partial words and gaps
    for (int m = 0; m < 12; m++) begin
      int nw;
      nw = $urandom_range(6, 1);
      w = {}; nb = {};
      for (int i = 0; i < nw; i++) begin
        w.push_back($urandom);
        nb.push_back(2'($urandom_range(3, 0)));
      end
      run_msg("rnd", w, nb, 2, 1'b1);
      do_ack("rnd");
    end

    // Result held across ack outside DONE being ignored
    held = crc_o;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("idle_ack_keep", crc_o, held);
    chk("idle_ack_busy", {31'h0, busy_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
